// File: rtl/pat_multi_engine.sv
// Multi-paddle motion datapath: decodes sensor motion codes per channel and
// integrates velocity into clamped screen positions on each frame tick.
module pat_chan #(
    parameter int X_W        = 11,
    parameter int Y_W        = 11,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int INIT_X     = 40,
    parameter int INIT_Y     = 240,
    parameter int SWING_THR  = 8,
    parameter int SWING_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               tick,
    input  logic               load,
    input  logic               zero,
    input  logic [13:0]        vel,
    output logic [X_W+Y_W-1:0] loc,
    output logic               swing
);
    localparam logic signed [X_W+1:0] XLO  = (X_W+2)'(X_MIN);
    localparam logic signed [X_W+1:0] XHI  = (X_W+2)'(X_MAX);
    localparam logic signed [Y_W+1:0] YLO  = (Y_W+2)'(Y_MIN);
    localparam logic signed [Y_W+1:0] YHI  = (Y_W+2)'(Y_MAX);
    localparam logic [5:0]            THR  = 6'(SWING_THR);
    localparam logic [3:0]            HOLD = 4'(SWING_HOLD);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [13:0]    vel_q, vel_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           swing_q;
    logic signed [X_W+1:0] dx, xs;
    logic signed [Y_W+1:0] dy, ys;
    logic           trig;

    always_comb begin
        dx = $signed((X_W+2)'(vel_q[12:7]));
        dy = $signed((Y_W+2)'(vel_q[5:0]));
        // Two guard bits keep the sum from wrapping before the clamp.
        xs = $signed({2'b00, x_q}) + (vel_q[13] ? dx : -dx);
        ys = $signed({2'b00, y_q}) + (vel_q[6] ? -dy : dy);
        trig = load && vel[6] && (vel[5:0] >= THR);

        vel_d = vel_q;
        if (zero) vel_d = '0;
        if (load) vel_d = vel;

        x_d = x_q;
        y_d = y_q;
        cnt_d = cnt_q;
        if (tick) begin
            if (xs < XLO)      x_d = XLO[X_W-1:0];
            else if (xs > XHI) x_d = XHI[X_W-1:0];
            else               x_d = xs[X_W-1:0];
            if (ys < YLO)      y_d = YLO[Y_W-1:0];
            else if (ys > YHI) y_d = YHI[Y_W-1:0];
            else               y_d = ys[Y_W-1:0];
            if (cnt_q != '0)   cnt_d = cnt_q - 4'd1;
        end
        if (trig) cnt_d = HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            x_q     <= X_W'(INIT_X);
            y_q     <= Y_W'(INIT_Y);
            vel_q   <= '0;
            cnt_q   <= '0;
            swing_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            cnt_q   <= cnt_d;
            swing_q <= (cnt_d != '0);
        end
    end

    assign loc   = {x_q, y_q};
    assign swing = swing_q;
endmodule

module pat_multi_engine #(
    parameter int NUM_PAT     = 2,
    parameter int X_W         = 11,
    parameter int Y_W         = 11,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int INIT_X0     = 40,
    parameter int INIT_X_STEP = 560,
    parameter int INIT_Y      = 240,
    parameter int SWING_THR   = 8,
    parameter int SWING_HOLD  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_pat,
    input  logic                           fetch,
    input  logic [1:0]                     code_ch,
    input  logic [15:0]                    code,
    input  logic                           update_pat,
    output logic [NUM_PAT*(X_W+Y_W)-1:0]   pat_location,
    output logic [NUM_PAT-1:0]             swing,
    output logic                           clear,
    output logic                           stall
);
    logic ch_ok, is_move, is_clr, is_stall, tick;
    logic stall_q, stall_d, clear_q, clear_d;

    always_comb begin
        ch_ok    = fetch && (int'(code_ch) < NUM_PAT);
        is_move  = ch_ok && (code[15:14] == 2'b00);
        is_clr   = ch_ok && (code[15:14] == 2'b01);
        is_stall = ch_ok && (code[15:14] == 2'b10);
        // A stall code arriving with the tick already suppresses that tick.
        tick     = update_pat && !stall_q && !is_stall;
        clear_d  = is_clr;
        stall_d  = stall_q;
        if (is_move || is_clr) stall_d = 1'b0;
        if (is_stall)          stall_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || init_pat) begin
            stall_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            clear_q <= clear_d;
        end
    end

    assign stall = stall_q;
    assign clear = clear_q;

    for (genvar c = 0; c < NUM_PAT; c++) begin : g_ch
        logic load_c;
        assign load_c = is_move && (code_ch == 2'(c));
        pat_chan #(
            .X_W(X_W), .Y_W(Y_W), .X_MIN(X_MIN), .X_MAX(X_MAX),
            .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
            .INIT_X(INIT_X0 + c*INIT_X_STEP), .INIT_Y(INIT_Y),
            .SWING_THR(SWING_THR), .SWING_HOLD(SWING_HOLD)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .init  (init_pat),
            .tick  (tick),
            .load  (load_c),
            .zero  (is_clr),
            .vel   (code[13:0]),
            .loc   (pat_location[c*(X_W+Y_W) +: X_W+Y_W]),
            .swing (swing[c])
        );
    end
endmodule

// File: tb/tb_pat_multi_engine.sv
// Directed vector bench for pat_multi_engine with two paddle channels.
module tb_pat_multi_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0, init_pat = 1'b0, fetch = 1'b0, update_pat = 1'b0;
    logic [1:0]  code_ch = '0;
    logic [15:0] code = '0;
    logic [43:0] pat_location;
    logic [1:0]  swing;
    logic        clear, stall;

    int n_chk = 0;
    int n_pass = 0;

    pat_multi_engine dut (
        .clk(clk), .rst(rst), .init_pat(init_pat), .fetch(fetch),
        .code_ch(code_ch), .code(code), .update_pat(update_pat),
        .pat_location(pat_location), .swing(swing), .clear(clear), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, i, f;
        logic [1:0] ch;
        logic [15:0] code;
        logic u;
        int x0, y0, x1, y1;
        logic [1:0] sw;
        logic cl, st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic i, input logic f, input logic [1:0] ch,
                       input logic [15:0] cd, input logic u, input int x0, input int y0,
                       input int x1, input int y1, input logic [1:0] sw, input logic cl,
                       input logic st);
        vec_t v;
        v.r = r; v.i = i; v.f = f; v.ch = ch; v.code = cd; v.u = u;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.sw = sw; v.cl = cl; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    endtask

    task automatic drive(input logic r, input logic i, input logic f, input logic [1:0] ch,
                         input logic [15:0] cd, input logic u);
        @(negedge clk);
        rst = r; init_pat = i; fetch = f; code_ch = ch; code = cd; update_pat = u;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input int x0, input int y0, input int x1,
                             input int y1, input logic [1:0] sw, input logic cl, input logic st);
        chk("x0", idx, int'(pat_location[21:11]), x0);
        chk("y0", idx, int'(pat_location[10:0]), y0);
        chk("x1", idx, int'(pat_location[43:33]), x1);
        chk("y1", idx, int'(pat_location[32:22]), y1);
        chk("swing", idx, int'(swing), int'(sw));
        chk("clear", idx, int'(clear), int'(cl));
        chk("stall", idx, int'(stall), int'(st));
    endtask

    initial begin
        // r i f ch code u | x0 y0 x1 y1 sw cl st
        add(1,0,0,0,16'h0000,0, 40,240,600,240, 2'b00,0,0);
        for (int k = 0; k < 3; k++) add(0,0,0,0,16'h0000,1, 40,240,600,240, 2'b00,0,0);
        add(0,0,1,0,16'h2142,0, 40,240,600,240, 2'b00,0,0);
        for (int k = 1; k <= 5; k++) add(0,0,0,0,16'h0000,1, 40+2*k,240-2*k,600,240, 2'b00,0,0);
        add(0,0,1,0,16'h0000,0, 50,230,600,240, 2'b00,0,0);
        add(0,0,1,1,16'h3F80,0, 50,230,600,240, 2'b00,0,0);
        for (int k = 0; k < 5; k++) add(0,0,0,0,16'h0000,1, 50,230,639,240, 2'b00,0,0);
        add(0,0,1,1,16'h003F,0, 50,230,639,240, 2'b00,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,303, 2'b00,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,366, 2'b00,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,429, 2'b00,0,0);
        for (int k = 0; k < 7; k++) add(0,0,0,0,16'h0000,1, 50,230,639,479, 2'b00,0,0);
        // swing: 4 ticks then falls
        add(0,0,1,1,16'h0048,0, 50,230,639,479, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,471, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,463, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,455, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,447, 2'b00,0,0);
        // retrigger on the second tick, together with that tick
        add(0,0,1,1,16'h0048,0, 50,230,639,447, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,439, 2'b10,0,0);
        add(0,0,1,1,16'h0048,1, 50,230,639,431, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,423, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,415, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,407, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,399, 2'b00,0,0);
        // stall (with a simultaneous tick), frozen ticks, then clear
        add(0,0,1,1,16'h0048,0, 50,230,639,399, 2'b10,0,0);
        add(0,0,1,0,16'h8000,1, 50,230,639,399, 2'b10,0,1);
        for (int k = 0; k < 3; k++) add(0,0,0,0,16'h0000,1, 50,230,639,399, 2'b10,0,1);
        add(0,0,1,1,16'h4000,0, 50,230,639,399, 2'b10,1,0);
        add(0,0,0,0,16'h0000,1, 50,230,639,399, 2'b10,0,0);
        // fetch + tick same channel: old (zero) velocity used
        add(0,0,1,0,16'h2142,1, 50,230,639,399, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 52,228,639,399, 2'b10,0,0);
        add(0,0,0,0,16'h0000,1, 54,226,639,399, 2'b00,0,0);
        // out-of-range channel stall code ignored, tick still applies
        add(0,0,1,3,16'h8000,1, 56,224,639,399, 2'b00,0,0);
        add(0,0,1,0,16'h8000,0, 56,224,639,399, 2'b00,0,1);
        add(0,0,1,0,16'h0000,0, 56,224,639,399, 2'b00,0,0);
        add(0,0,0,0,16'h0000,1, 56,224,639,399, 2'b00,0,0);
        // init_pat with tick wins and drops a live swing
        add(0,0,1,0,16'h0048,0, 56,224,639,399, 2'b01,0,0);
        add(0,1,0,0,16'h0000,1, 40,240,600,240, 2'b00,0,0);
        add(0,0,0,0,16'h0000,1, 40,240,600,240, 2'b00,0,0);
        add(0,0,1,1,16'h3F80,0, 40,240,600,240, 2'b00,0,0);
        add(1,0,0,0,16'h0000,0, 40,240,600,240, 2'b00,0,0);
        add(0,0,0,0,16'h0000,1, 40,240,600,240, 2'b00,0,0);

        foreach (vecs[n]) begin
            drive(vecs[n].r, vecs[n].i, vecs[n].f, vecs[n].ch, vecs[n].code, vecs[n].u);
            check_all(n, vecs[n].x0, vecs[n].y0, vecs[n].x1, vecs[n].y1,
                      vecs[n].sw, vecs[n].cl, vecs[n].st);
        end

        // rst beats a same-cycle swing trigger
        drive(0,0,1,1,16'h0048,0);
        check_all(100, 40,240,600,240, 2'b10,0,0);
        drive(1,0,1,0,16'h0048,0);
        check_all(101, 40,240,600,240, 2'b00,0,0);
        // init_pat held: blocks moves, ticks and clear codes
        drive(0,1,1,0,16'h2142,1);
        check_all(102, 40,240,600,240, 2'b00,0,0);
        drive(0,1,1,0,16'h4000,1);
        check_all(103, 40,240,600,240, 2'b00,0,0);
        drive(0,0,0,0,16'h0000,1);
        check_all(104, 40,240,600,240, 2'b00,0,0);
        // opcode 11 is ignored; x low clamp
        drive(0,0,1,0,16'hFFFF,1);
        check_all(105, 40,240,600,240, 2'b00,0,0);
        drive(0,0,1,0,16'h1F80,0);
        check_all(106, 40,240,600,240, 2'b00,0,0);
        drive(0,0,0,0,16'h0000,1);
        check_all(107, 0,240,600,240, 2'b00,0,0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
